// File: rtl/laser_pkg.sv
// Shared definitions for the single-laser byte link (transmit and receive sides).
package laser_pkg;

    localparam int LASER_OVERSAMPLE = 8;
    localparam int LASER_DATA_BITS  = 8;

    localparam logic LINE_IDLE  = 1'b0;
    localparam logic LINE_START = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } deframer_state_t;

endpackage

// File: rtl/laser_bit_sync.sv
// Two-flop synchronizer for one asynchronous laser photodiode level.
module laser_bit_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/laser_byte_deframer.sv
// Laser link receiver: oversampled frame recovery into a valid/ready holding register.
module laser_byte_deframer
    import laser_pkg::*;
#(
    parameter int OVERSAMPLE = LASER_OVERSAMPLE,
    parameter int DATA_BITS  = LASER_DATA_BITS
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 laser_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic sync_in;

    deframer_state_t      state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 good, good_next;
    logic                 ferr_next;

    laser_bit_sync u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (laser_in),
        .sync_out (sync_in)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            good    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            good    <= good_next;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        good_next    = 1'b0;
        ferr_next    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (sync_in == LINE_START) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                // Re-check the start bit at its midpoint; a short pulse is a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (sync_in == LINE_START) begin
                        state_next   = ST_DATA;
                        bit_idx_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_next[bit_idx] = sync_in;
                    cnt_next            = '0;
                    if (bit_idx == BIT_LAST) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (sync_in == LINE_IDLE) begin
                        state_next = ST_IDLE;
                        good_next  = 1'b1;
                    end else begin
                        state_next = ST_WAIT_IDLE;
                        ferr_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (sync_in == LINE_IDLE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A good byte may load in the same cycle the held byte is consumed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= ferr_next;
            overrun   <= 1'b0;
            if (good) begin
                if (!data_valid || data_ready) begin
                    data_out   <= shift;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule
